i2c_txn_sequencer: RTL and testbench

// - Transaction controller between the APB slave register block and the I2C byte engine.
// - Takes the control bytes i2c_con1/i2c_con2 and write word Din written over APB.
// - Issues START, ADDR, WRITE/READ and STOP commands to the byte engine.
// - Returns i2c_stat, Dout and ready to the APB side.

---
 rtl/i2c_ctrl_pkg.sv | 29 ++
 rtl/i2c_seq_wdog.sv | 26 ++
 rtl/i2c_txn_sequencer.sv | 179 +++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared encodings for the I2C transaction sequencer: FSM states, engine commands,
// status and control-byte field positions.
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WR, S_RD, S_STOP, S_DONE
  } state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam int STAT_DONE    = 7;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_NACK    = 1;
  localparam int STAT_BUSY    = 0;

  localparam int CON1_GO      = 0;
  localparam int CON1_RW      = 1;
  localparam int CON1_CNT_LSB = 2;

  localparam int WDOG_W = 13;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// Per-command watchdog: counts cycles while a command is outstanding and flags
// the terminal count. Only instantiated when I2C_WDOG_EN is defined.
module i2c_seq_wdog
  import i2c_ctrl_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic hit
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run) count <= '0;
    else                       count <= count + WDOG_W'(1);
  end

  assign hit = (count == LAST);

endmodule

// File: rtl/i2c_txn_sequencer.sv
// APB-to-byte-engine I2C transaction sequencer (START, ADDR, data bytes, STOP).
// Optional per-command watchdog enabled with the I2C_WDOG_EN macro.
//
// state   | meaning
// IDLE    | ready, waiting for a go rising edge
// START   | START command outstanding
// ADDR    | address byte {addr,rw} outstanding
// WR      | data byte idx being written
// RD      | data byte idx being read
// STOP    | STOP command outstanding
// DONE    | one cycle: post done, drop busy
module i2c_txn_sequencer
  import i2c_ctrl_pkg::*;
#(
  parameter int NBYTES_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [7:0]              i2c_con1,
  input  logic [7:0]              i2c_con2,
  input  logic [8*NBYTES_MAX-1:0] Din,
  output logic [8*NBYTES_MAX-1:0] Dout,
  output logic                    ready,
  output logic [7:0]              i2c_stat,
  output logic [1:0]              eng_cmd,
  output logic                    eng_valid,
  output logic [7:0]              eng_txbyte,
  output logic                    eng_last,
  input  logic                    eng_ack,
  input  logic [7:0]              eng_rxbyte,
  input  logic                    eng_nack
);

  state_t                  state;
  logic                    go_q;
  logic [6:0]              addr_q;
  logic                    rw_q;
  logic [1:0]              cnt_q;
  logic [8*NBYTES_MAX-1:0] din_q;
  logic [1:0]              idx;
  logic                    done_q, nack_q, to_q, busy_q;
  logic                    wdog_hit;
  logic                    go_edge;
  logic [1:0]              idx_nx;
  logic                    unused_ok;

`ifdef I2C_WDOG_EN
  i2c_seq_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .run   (eng_valid),
    .clr   (eng_ack),
    .hit   (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  assign go_edge   = i2c_con1[CON1_GO] && !go_q;
  assign idx_nx    = idx + 2'd1;
  assign unused_ok = ^{i2c_con1[7:4], i2c_con2[7], TIMEOUT_CYCLES[0]};

  always_comb begin
    i2c_stat               = 8'h00;
    i2c_stat[STAT_DONE]    = done_q;
    i2c_stat[STAT_TIMEOUT] = to_q;
    i2c_stat[STAT_NACK]    = nack_q;
    i2c_stat[STAT_BUSY]    = busy_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      go_q       <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      din_q      <= '0;
      idx        <= '0;
      Dout       <= '0;
      ready      <= 1'b1;
      eng_cmd    <= CMD_START;
      eng_valid  <= 1'b0;
      eng_txbyte <= '0;
      eng_last   <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      go_q <= i2c_con1[CON1_GO];
      case (state)
        S_IDLE: begin
          if (go_edge) begin
            addr_q   <= i2c_con2[6:0];
            rw_q     <= i2c_con1[CON1_RW];
            cnt_q    <= i2c_con1[CON1_CNT_LSB +: 2];
            din_q    <= Din;
            Dout     <= '0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b1;
            ready    <= 1'b0;
            idx      <= '0;
            eng_cmd  <= CMD_START;
            eng_last <= 1'b0;
            state    <= S_START;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          ready  <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          // Command states: raise valid one cycle after entry, advance on ack.
          if (!eng_valid) begin
            eng_valid <= 1'b1;
          end else if (eng_ack) begin
            eng_valid <= 1'b0;
            case (state)
              S_START: begin
                eng_cmd    <= CMD_WRITE;
                eng_txbyte <= addr_byte(addr_q, rw_q);
                state      <= S_ADDR;
              end
              S_ADDR: begin
                if (eng_nack) begin
                  nack_q  <= 1'b1;
                  eng_cmd <= CMD_STOP;
                  state   <= S_STOP;
                end else if (rw_q) begin
                  eng_cmd  <= CMD_READ;
                  eng_last <= (cnt_q == 2'd0);
                  state    <= S_RD;
                end else begin
                  eng_cmd    <= CMD_WRITE;
                  eng_txbyte <= din_q[7:0];
                  state      <= S_WR;
                end
              end
              S_WR: begin
                if (eng_nack || idx == cnt_q) begin
                  nack_q  <= nack_q | eng_nack;
                  eng_cmd <= CMD_STOP;
                  state   <= S_STOP;
                end else begin
                  idx        <= idx_nx;
                  eng_txbyte <= din_q[8*idx_nx +: 8];
                end
              end
              S_RD: begin
                Dout[8*idx +: 8] <= eng_rxbyte;
                if (idx == cnt_q) begin
                  eng_cmd  <= CMD_STOP;
                  eng_last <= 1'b0;
                  state    <= S_STOP;
                end else begin
                  idx      <= idx_nx;
                  eng_last <= (idx_nx == cnt_q);
                end
              end
              S_STOP:  state <= S_DONE;
              default: state <= S_IDLE;
            endcase
          end else if (wdog_hit) begin
            eng_valid <= 1'b0;
            to_q      <= 1'b1;
            state     <= S_DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Randomized self-checking bench for i2c_txn_sequencer with a transaction-level
// model of the expected engine command stream, Dout and status.
module tb_i2c_txn_sequencer;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_WRITE = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_STOP  = 2'd3;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  i2c_con1 = 8'h00;
  logic [7:0]  i2c_con2 = 8'h00;
  logic [31:0] Din = 32'h0;
  logic [31:0] Dout;
  logic        ready;
  logic [7:0]  i2c_stat;
  logic [1:0]  eng_cmd;
  logic        eng_valid;
  logic [7:0]  eng_txbyte;
  logic        eng_last;
  logic        eng_ack = 1'b0;
  logic [7:0]  eng_rxbyte = 8'h00;
  logic        eng_nack = 1'b0;

  i2c_txn_sequencer #(.NBYTES_MAX(4), .TIMEOUT_CYCLES(16)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .i2c_con1   (i2c_con1),
    .i2c_con2   (i2c_con2),
    .Din        (Din),
    .Dout       (Dout),
    .ready      (ready),
    .i2c_stat   (i2c_stat),
    .eng_cmd    (eng_cmd),
    .eng_valid  (eng_valid),
    .eng_txbyte (eng_txbyte),
    .eng_last   (eng_last),
    .eng_ack    (eng_ack),
    .eng_rxbyte (eng_rxbyte),
    .eng_nack   (eng_nack)
  );

  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_dout;
  logic [7:0]  exp_stat;
  logic [7:0]  rx_plan[4];
  int          nack_cmd = -1;
  int          cmd_no = 0;
  int          delay = 0;
  bit          eng_hold = 1'b0;
  bit          wdog_test = 1'b0;
  bit          in_reset = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
    #3;
  endtask

  // Expected command stream, read data and status of one transaction.
  task automatic build_model(input logic [6:0] a, input logic rw, input logic [1:0] c,
                             input logic [31:0] d, input int nk);
    exp_t e;
    bit   ab = 1'b0;
    exp_q.delete();
    exp_dout = 32'h0;
    exp_stat = 8'h80;
    e.cmd = C_START; e.b = 8'h00; e.last = 1'b0; exp_q.push_back(e);
    e.cmd = C_WRITE; e.b = {a, rw}; exp_q.push_back(e);
    if (nk == 1) begin exp_stat = 8'h82; ab = 1'b1; end
    for (int i = 0; i <= int'(c) && !ab; i++) begin
      if (!rw) begin
        e.cmd = C_WRITE; e.b = d[8*i +: 8]; e.last = 1'b0; exp_q.push_back(e);
        if (nk == 2 + i) begin exp_stat = 8'h82; ab = 1'b1; end
      end else begin
        e.cmd = C_READ; e.b = 8'h00; e.last = (i == int'(c)); exp_q.push_back(e);
        exp_dout[8*i +: 8] = rx_plan[i];
      end
    end
    e.cmd = C_STOP; e.b = 8'h00; e.last = 1'b0; exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 2000) begin step(); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL %s: ready timeout, got 0, expected 1", name);
    end
  endtask

  task automatic run_txn(input logic [6:0] a, input logic rw, input logic [1:0] c,
                         input logic [31:0] d, input int nk, input bit mess);
    build_model(a, rw, c, d, nk);
    nack_cmd = nk;
    cmd_no   = 0;
    i2c_con2 = {1'b0, a};
    Din      = d;
    i2c_con1 = {4'h0, c, rw, 1'b1};
    step();
    check("launch_ready", {31'h0, ready}, 32'h0);
    check("launch_stat", {24'h0, i2c_stat}, 32'h01);
    if (mess) begin
      for (int k = 0; k < 4; k++) begin
        step();
        Din      = $urandom;
        i2c_con2 = 8'($urandom);
        i2c_con1 = {4'($urandom), 2'($urandom), 1'($urandom), (k % 2 == 1)};
      end
    end
    wait_ready("txn_done");
    check("stat", {24'h0, i2c_stat}, {24'h0, exp_stat});
    check("dout", Dout, exp_dout);
    check("cmds_left", exp_q.size(), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("no_relaunch", {30'h0, ready, eng_valid}, 32'h2);
    end
    i2c_con1 = 8'h00;
    step();
  endtask

  // Engine model: acks each command after 0..3 cycles.
  initial begin
    forever begin
      @(negedge PCLK);
      #1;
      if (eng_ack) begin
        eng_ack    = 1'b0;
        eng_nack   = 1'b0;
        eng_rxbyte = 8'h00;
        delay      = $urandom_range(0, 3);
      end else if (eng_valid && PRESETn && !eng_hold) begin
        if (delay > 0) delay--;
        else begin
          eng_ack  = 1'b1;
          eng_nack = (eng_cmd == C_WRITE) && (cmd_no == nack_cmd);
          if (eng_cmd == C_READ && cmd_no >= 2 && cmd_no <= 5) eng_rxbyte = rx_plan[cmd_no-2];
          cmd_no++;
        end
      end
    end
  end

  // Per-cycle handshake compare against the model command stream.
  bit         pv = 1'b0, pa = 1'b0;
  logic [1:0] pc;
  logic [7:0] pt;
  logic       pl;
  exp_t       ce;
  initial begin
    forever begin
      @(negedge PCLK);
      #2;
      if (in_reset || !PRESETn) begin
        pv = 1'b0; pa = 1'b0;
      end else begin
        if (pv && pa) check("valid_drop", {31'h0, eng_valid}, 32'h0);
        else if (pv && !wdog_test) begin
          check("valid_hold", {31'h0, eng_valid}, 32'h1);
          check("cmd_stable", {15'h0, eng_cmd, eng_txbyte, eng_last}, {15'h0, pc, pt, pl});
        end
        if (eng_valid && eng_ack) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd: got cmd %0d, expected none", eng_cmd);
          end else begin
            ce = exp_q.pop_front();
            check("cmd", {30'h0, eng_cmd}, {30'h0, ce.cmd});
            if (ce.cmd == C_WRITE) check("txbyte", {24'h0, eng_txbyte}, {24'h0, ce.b});
            if (ce.cmd == C_READ)  check("last", {31'h0, eng_last}, {31'h0, ce.last});
          end
        end
        pv = eng_valid; pa = eng_ack; pc = eng_cmd; pt = eng_txbyte; pl = eng_last;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nk, n;
    logic rw;
    logic [1:0] c;

    for (int i = 0; i < 4; i++) rx_plan[i] = 8'h00;
    repeat (3) step();
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_stat", {24'h0, i2c_stat}, 32'h0);
    check("rst_dout", Dout, 32'h0);
    check("rst_eng", {20'h0, eng_cmd, eng_valid, eng_txbyte, eng_last}, 32'h0);
    PRESETn = 1'b1;
    step();

    // Directed write, model pinned against hand-computed stream.
    build_model(7'h50, 1'b0, 2'd1, 32'h0000BEEF, -1);
    check("model_w_len", exp_q.size(), 5);
    check("model_w_addr", {24'h0, exp_q[1].b}, 32'hA0);
    check("model_w_b0", {24'h0, exp_q[2].b}, 32'hEF);
    check("model_w_b1", {24'h0, exp_q[3].b}, 32'hBE);
    check("model_w_stop", {30'h0, exp_q[4].cmd}, {30'h0, C_STOP});
    run_txn(7'h50, 1'b0, 2'd1, 32'h0000BEEF, -1, 1'b0);
    check("w_stat_lit", {24'h0, i2c_stat}, 32'h80);
    check("w_ready_lit", {31'h0, ready}, 32'h1);

    // Directed read of 4 bytes.
    rx_plan[0] = 8'h11; rx_plan[1] = 8'h22; rx_plan[2] = 8'h33; rx_plan[3] = 8'h44;
    build_model(7'h51, 1'b1, 2'd3, 32'h0, -1);
    check("model_r_addr", {24'h0, exp_q[1].b}, 32'hA3);
    check("model_r_last3", {31'h0, exp_q[4].last}, 32'h0);
    check("model_r_last4", {31'h0, exp_q[5].last}, 32'h1);
    run_txn(7'h51, 1'b1, 2'd3, 32'h0, -1, 1'b0);
    check("r_dout_lit", Dout, 32'h44332211);
    check("r_stat_lit", {24'h0, i2c_stat}, 32'h80);

    // Address NACK and data NACK on byte 1 of 3.
    build_model(7'h3C, 1'b0, 2'd2, 32'h00C0FFEE, 1);
    check("model_anack_len", exp_q.size(), 3);
    run_txn(7'h3C, 1'b0, 2'd2, 32'h00C0FFEE, 1, 1'b0);
    check("anack_stat_lit", {24'h0, i2c_stat}, 32'h82);
    run_txn(7'h2A, 1'b0, 2'd2, 32'h00123456, 3, 1'b0);
    check("dnack_stat_lit", {24'h0, i2c_stat}, 32'h82);

    // Busy-time go toggles and Din changes must not leak into the transfer.
    run_txn(7'h11, 1'b0, 2'd3, 32'hA1B2C3D4, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom);
      c  = 2'($urandom);
      nk = -1;
      if ($urandom_range(0, 3) == 0) nk = rw ? 1 : int'($urandom_range(1, 2 + int'(c)));
      for (int i = 0; i < 4; i++) rx_plan[i] = 8'($urandom);
      run_txn(7'($urandom), rw, c, $urandom, nk, 1'($urandom));
    end

    // Reset in the middle of a read.
    for (int i = 0; i < 4; i++) rx_plan[i] = 8'($urandom);
    build_model(7'h33, 1'b1, 2'd3, 32'h0, -1);
    nack_cmd = -1; cmd_no = 0;
    i2c_con2 = 8'h33; i2c_con1 = 8'h0F;
    n = 0;
    step();
    while (!(eng_valid && eng_cmd == C_READ) && n < 500) begin step(); n++; end
    check("rd_reached", {31'h0, eng_valid && eng_cmd == C_READ}, 32'h1);
    in_reset = 1'b1; PRESETn = 1'b0; i2c_con1 = 8'h00;
    step();
    check("mid_rst_ready", {31'h0, ready}, 32'h1);
    check("mid_rst_valid", {31'h0, eng_valid}, 32'h0);
    check("mid_rst_stat", {24'h0, i2c_stat}, 32'h0);
    check("mid_rst_dout", Dout, 32'h0);
    check("mid_rst_eng", {21'h0, eng_cmd, eng_txbyte, eng_last}, 32'h0);
    PRESETn = 1'b1;
    step();
    step();
    exp_q.delete();
    in_reset = 1'b0;
    run_txn(7'h44, 1'b1, 2'd0, 32'h0, -1, 1'b0);

`ifdef I2C_WDOG_EN
    eng_hold = 1'b1; wdog_test = 1'b1;
    i2c_con2 = 8'h22; i2c_con1 = 8'h01;
    n = 0;
    step();
    while (!eng_valid && n < 100) begin step(); n++; end
    n = 0;
    while (eng_valid && n < 100) begin n++; step(); end
    check("wdog_valid_cycles", n, 16);
    wait_ready("wdog_done");
    check("wdog_stat", {24'h0, i2c_stat}, 32'h84);
    exp_q.delete();
    i2c_con1 = 8'h00; eng_hold = 1'b0;
    step();
    wdog_test = 1'b0;
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
